alu_cmd_serializer: RTL and testbench

- Upstream feeder for the serial 4-slot ALU (slots: opcode, A, B, result-capture).
- Accepts parallel commands (op, A, B) over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each command onto the ALU's 8-bit input bus in slot order, then captures the ALU's registered result and presents it with a valid/ready handshake.

---
 rtl/alu_cmd_pkg.sv | 26 ++
 rtl/alu_cmd_fifo.sv | 55 +++++
 rtl/alu_cmd_serializer.sv | 171 +++++++++++++++++
 tb/tb_alu_cmd_serializer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_pkg.sv
// Shared opcode/phase constants and command layout for the ALU command serializer.
package alu_cmd_pkg;

  localparam int unsigned CmdDataW = 8;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;

  localparam logic [1:0] PH_OP  = 2'd0;
  localparam logic [1:0] PH_A   = 2'd1;
  localparam logic [1:0] PH_B   = 2'd2;
  localparam logic [1:0] PH_RES = 2'd3;

  typedef struct packed {
    logic [3:0]          op;
    logic [CmdDataW-1:0] a;
    logic [CmdDataW-1:0] b;
  } cmd_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_OR;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with count-based full/empty; Depth must be a power of two.
module alu_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q + PtrW'(push_ok);
    rptr_d  = rptr_q + PtrW'(pop_ok);
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/alu_cmd_serializer.sv
// Buffers parallel ALU commands and serializes them onto the 4-slot ALU bus, capturing results.
// Optional opcode check enabled by defining ALU_CMD_OPCHECK_EN (adds res_err_o).
module alu_cmd_serializer
  import alu_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = CmdDataW
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [3:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  output logic [DATA_W-1:0] alu_in_o,
  output logic              frame_start_o,
  input  logic [DATA_W-1:0] alu_out_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic [3:0]        res_op_o,
  output logic              res_overrun_o
`ifdef ALU_CMD_OPCHECK_EN
  ,
  output logic              res_err_o
`endif
);

  localparam int unsigned CmdW = 4 + 2 * DATA_W;

  logic [CmdW-1:0]   fifo_rdata;
  logic              fifo_full, fifo_empty, push, pop, head_bad, capture;
  logic [3:0]        head_op;
  logic [DATA_W-1:0] head_a, head_b;

  logic [1:0]        phase_q, phase_d;
  logic              frame_busy_q, frame_busy_d, frame_bad_q, frame_bad_d;
  logic [3:0]        frame_op_q, frame_op_d, prev_op_q, prev_op_d;
  logic [DATA_W-1:0] frame_a_q, frame_a_d, frame_b_q, frame_b_d;
  logic              pending_q, pending_d, prev_bad_q, prev_bad_d;
  logic              res_valid_q, res_valid_d, res_overrun_q, res_overrun_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [3:0]        res_op_q, res_op_d;
  logic              res_err_q, res_err_d;

  assign push = cmd_valid_i && !fifo_full;
  assign pop  = (phase_q == PH_RES) && !fifo_empty;

  alu_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CmdW)
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .push_i  (push),
    .wdata_i ({cmd_op_i, cmd_a_i, cmd_b_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_op = fifo_rdata[CmdW-1 -: 4];
  assign head_a  = fifo_rdata[2*DATA_W-1 -: DATA_W];
  assign head_b  = fifo_rdata[DATA_W-1:0];

`ifdef ALU_CMD_OPCHECK_EN
  assign head_bad  = !op_is_legal(head_op);
  assign res_err_o = res_err_q;
`else
  assign head_bad  = 1'b0;
`endif

  always_comb begin
    phase_d       = phase_q + 2'd1;
    frame_busy_d  = frame_busy_q;
    frame_bad_d   = frame_bad_q;
    frame_op_d    = frame_op_q;
    frame_a_d     = frame_a_q;
    frame_b_d     = frame_b_q;
    pending_d     = pending_q;
    prev_op_d     = prev_op_q;
    prev_bad_d    = prev_bad_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_op_d      = res_op_q;
    res_overrun_d = res_overrun_q;
    res_err_d     = res_err_q;
    capture       = (phase_q == PH_OP) && pending_q;

    // Edge into phase 0: hand the ending frame to the result stage and load the next one.
    if (phase_q == PH_RES) begin
      pending_d    = frame_busy_q;
      prev_op_d    = frame_op_q;
      prev_bad_d   = frame_bad_q;
      frame_busy_d = pop;
      frame_bad_d  = pop && head_bad;
      frame_op_d   = pop ? head_op : '0;
      frame_a_d    = (pop && !head_bad) ? head_a : '0;
      frame_b_d    = (pop && !head_bad) ? head_b : '0;
    end

    if (capture) begin
      pending_d     = 1'b0;
      res_valid_d   = 1'b1;
      res_data_d    = prev_bad_q ? '0 : alu_out_i;
      res_op_d      = prev_op_q;
      res_err_d     = prev_bad_q;
      res_overrun_d = res_overrun_q || (res_valid_q && !res_ready_i);
    end else if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
      res_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      phase_q       <= PH_OP;
      frame_busy_q  <= 1'b0;
      frame_bad_q   <= 1'b0;
      frame_op_q    <= '0;
      frame_a_q     <= '0;
      frame_b_q     <= '0;
      pending_q     <= 1'b0;
      prev_op_q     <= '0;
      prev_bad_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_op_q      <= '0;
      res_overrun_q <= 1'b0;
      res_err_q     <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      frame_busy_q  <= frame_busy_d;
      frame_bad_q   <= frame_bad_d;
      frame_op_q    <= frame_op_d;
      frame_a_q     <= frame_a_d;
      frame_b_q     <= frame_b_d;
      pending_q     <= pending_d;
      prev_op_q     <= prev_op_d;
      prev_bad_q    <= prev_bad_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_op_q      <= res_op_d;
      res_overrun_q <= res_overrun_d;
      res_err_q     <= res_err_d;
    end
  end

  // Idle and rejected frames hold a zeroed a/b and are masked in the op slot.
  always_comb begin
    alu_in_o = '0;
    if (!frame_bad_q) begin
      case (phase_q)
        PH_OP:   alu_in_o = {{(DATA_W-4){1'b0}}, frame_op_q};
        PH_A:    alu_in_o = frame_a_q;
        PH_B:    alu_in_o = frame_b_q;
        default: alu_in_o = '0;
      endcase
    end
  end

  assign cmd_ready_o   = !fifo_full;
  assign frame_start_o = (phase_q == PH_OP);
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;
  assign res_op_o      = res_op_q;
  assign res_overrun_o = res_overrun_q;

endmodule

// File: tb/tb_alu_cmd_serializer.sv
// Randomized and directed bench for alu_cmd_serializer against a transaction-level model.
// Honours ALU_CMD_OPCHECK_EN the same way the design does.
module tb_alu_cmd_serializer;
  import alu_cmd_pkg::*;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, res_ready = 1'b0;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic       cmd_ready, frame_start, res_valid, res_overrun;
  logic [7:0] alu_in, alu_out, res_data;
  logic [3:0] res_op;
`ifdef ALU_CMD_OPCHECK_EN
  logic       res_err;
`endif

  always #5 clk = ~clk;

  alu_cmd_serializer #(
    .FIFO_DEPTH (Depth),
    .DATA_W     (8)
  ) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_op_i      (cmd_op),
    .cmd_a_i       (cmd_a),
    .cmd_b_i       (cmd_b),
    .alu_in_o      (alu_in),
    .frame_start_o (frame_start),
    .alu_out_i     (alu_out),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_data_o    (res_data),
    .res_op_o      (res_op),
    .res_overrun_o (res_overrun)
`ifdef ALU_CMD_OPCHECK_EN
    ,
    .res_err_o     (res_err)
`endif
  );

  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit is_bad(input logic [3:0] op);
`ifdef ALU_CMD_OPCHECK_EN
    return op > 4'd3;
`else
    return 1'b0;
`endif
  endfunction

  // Serial ALU stand-in: latches op/A/B in slots 0-2, registers the result at the end of slot 3.
  logic [1:0] alu_slot;
  logic [3:0] alu_op_r;
  logic [7:0] alu_a_r, alu_b_r;
  always @(posedge clk) begin
    if (rst) begin
      alu_slot <= 2'd0;
      alu_out  <= 8'h00;
      alu_op_r <= 4'h0;
      alu_a_r  <= 8'h00;
      alu_b_r  <= 8'h00;
    end else begin
      alu_slot <= alu_slot + 2'd1;
      case (alu_slot)
        2'd0:    alu_op_r <= alu_in[3:0];
        2'd1:    alu_a_r  <= alu_in;
        2'd2:    alu_b_r  <= alu_in;
        default: alu_out  <= alu_fn(alu_op_r, alu_a_r, alu_b_r);
      endcase
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference model
  typedef struct {
    int         due;
    logic [3:0] op;
    logic [7:0] data;
    bit         bad;
  } exp_t;

  int         m_phase = 0;
  int         m_cyc = 0;
  cmd_t       m_q[$];
  cmd_t       m_frame;
  bit         m_busy, m_rv, m_ovr, m_err;
  logic [7:0] m_data;
  logic [3:0] m_op;
  exp_t       m_sched[$];

  logic [7:0] got_data[$];
  int         got_cyc[$];
  bit         saw_not_ready;

  task automatic model_edge();
    int   pre_size;
    bit   was_rv;
    exp_t e;
    cmd_t c;
    if (rst) begin
      m_phase = 0; m_q.delete(); m_busy = 0; m_frame = '0; m_sched.delete();
      m_rv = 0; m_ovr = 0; m_err = 0; m_data = '0; m_op = '0;
      return;
    end
    m_cyc++;
    pre_size = m_q.size();
    was_rv   = m_rv;
    if (m_sched.size() > 0 && m_sched[0].due == m_cyc) begin
      e = m_sched.pop_front();
      if (was_rv && !res_ready) m_ovr = 1;
      m_rv = 1; m_data = e.data; m_op = e.op; m_err = e.bad;
    end else if (was_rv && res_ready) begin
      m_rv = 0; m_err = 0;
    end
    if (m_phase == 3) begin
      if (pre_size > 0) begin
        m_frame = m_q.pop_front();
        m_busy  = 1;
        e.due   = m_cyc + 5;
        e.op    = m_frame.op;
        e.bad   = is_bad(m_frame.op);
        e.data  = alu_fn(m_frame.op, m_frame.a, m_frame.b);
        m_sched.push_back(e);
      end else begin
        m_busy  = 0;
        m_frame = '0;
      end
    end
    if (cmd_valid && pre_size < Depth) begin
      c.op = cmd_op; c.a = cmd_a; c.b = cmd_b;
      m_q.push_back(c);
    end
    m_phase = (m_phase + 1) % 4;
  endtask

  function automatic logic [7:0] exp_alu_in();
    if (!m_busy || is_bad(m_frame.op)) return 8'h00;
    case (m_phase)
      0:       return {4'h0, m_frame.op};
      1:       return m_frame.a;
      2:       return m_frame.b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_outputs();
    check("cmd_ready", cmd_ready, m_q.size() < Depth);
    check("frame_start", frame_start, m_phase == 0);
    check("alu_in", alu_in, exp_alu_in());
    check("res_valid", res_valid, m_rv);
    check("res_data", res_data, m_data);
    check("res_op", res_op, m_op);
    check("res_overrun", res_overrun, m_ovr);
`ifdef ALU_CMD_OPCHECK_EN
    check("res_err", res_err, m_err);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (cmd_valid && !cmd_ready) saw_not_ready = 1;
    if (res_valid && res_ready) begin
      got_data.push_back(res_data);
      got_cyc.push_back(m_cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1; cmd_valid = 0;
    cycle();
    rst = 0;
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bit acc;
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    do begin
      acc = cmd_ready;
      cycle();
      n++;
    end while (!acc && n < 50);
    check("push_accepted", acc, 1);
    cmd_valid = 0;
  endtask

  task automatic wait_res(input string tag, input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      cycle();
      n++;
    end
    check(tag, res_valid, 1);
  endtask

  initial begin
    logic [7:0] exp6[6];
    logic [7:0] g;
    bit         seen;

    // Reset
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_alu_in", alu_in, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_overrun", res_overrun, 0);

    // Single add pushed at phase 1
    cycle();
    check("t1_phase1", frame_start, 0);
    push_cmd(4'd0, 8'd3, 8'd4);
    wait_res("t1_res_timeout", 20);
    check("t1_data", res_data, 8'd7);
    check("t1_op", res_op, 4'd0);
    res_ready = 1;
    cycle();

    // Back-to-back sub/and/or with consumer always ready
    got_data.delete(); got_cyc.delete();
    push_cmd(4'd1, 8'h01, 8'h02);
    push_cmd(4'd2, 8'h0F, 8'h3C);
    push_cmd(4'd3, 8'h50, 8'h05);
    repeat (20) cycle();
    check("t2_count", got_data.size(), 3);
    if (got_data.size() == 3) begin
      check("t2_r0", got_data[0], 8'hFF);
      check("t2_r1", got_data[1], 8'h0C);
      check("t2_r2", got_data[2], 8'h55);
      check("t2_gap0", got_cyc[1] - got_cyc[0], 4);
      check("t2_gap1", got_cyc[2] - got_cyc[1], 4);
    end

    // Six pushes into a 4-deep FIFO
    do_reset();
    res_ready = 1; saw_not_ready = 0;
    got_data.delete(); got_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      exp6[i] = alu_fn(4'd0, 8'(i * 16 + 1), 8'(i));
      push_cmd(4'd0, 8'(i * 16 + 1), 8'(i));
    end
    repeat (40) cycle();
    check("t3_backpressure", saw_not_ready, 1);
    check("t3_count", got_data.size(), 6);
    for (int i = 0; i < 6; i++) begin
      g = (i < got_data.size()) ? got_data[i] : 8'hxx;
      check("t3_order", g, exp6[i]);
    end

    // Overrun: two results, nobody consuming
    do_reset();
    res_ready = 0;
    push_cmd(4'd0, 8'h11, 8'h22);
    push_cmd(4'd3, 8'hA0, 8'h0A);
    repeat (20) cycle();
    check("t4_overrun", res_overrun, 1);
    check("t4_data", res_data, 8'hAA);

    // Capture and consume on the same edge: no overrun
    do_reset();
    res_ready = 0;
    push_cmd(4'd0, 8'h01, 8'h01);
    push_cmd(4'd1, 8'h09, 8'h04);
    wait_res("t4b_res_timeout", 20);
    repeat (3) cycle();
    res_ready = 1;
    cycle();
    check("t4b_overrun", res_overrun, 0);
    check("t4b_valid", res_valid, 1);
    check("t4b_data", res_data, 8'h05);
    cycle();

    // Reset in phase 2 of a busy frame, with an earlier result still held
    do_reset();
    res_ready = 0;
    push_cmd(4'd0, 8'h20, 8'h22);
    wait_res("t5_res_timeout", 20);
    push_cmd(4'd2, 8'hF3, 8'h3F);
    for (int n = 0; n < 20 && !(m_busy && m_phase == 2); n++) cycle();
    check("t5_reached_ph2", alu_in, 8'h3F);
    rst = 1;
    cycle();
    rst = 0;
    check("t5_valid", res_valid, 0);
    check("t5_data", res_data, 0);
    check("t5_op", res_op, 0);
    check("t5_alu_in", alu_in, 0);
    check("t5_ready", cmd_ready, 1);
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      cycle();
      if (res_valid) seen = 1;
    end
    check("t5_no_result", seen, 0);

    // Out-of-range opcode
    do_reset();
    res_ready = 0;
    push_cmd(4'd9, 8'h12, 8'h34);
    wait_res("t6_res_timeout", 20);
    check("t6_data", res_data, 0);
    check("t6_op", res_op, 4'd9);
`ifdef ALU_CMD_OPCHECK_EN
    check("t6_err", res_err, 1);
    res_ready = 1;
    cycle();
    check("t6_err_clr", res_err, 0);
`endif

    // Random traffic with one reset in the middle
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 4'($urandom_range(0, 5));
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rst       = (i == 200);
      cycle();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
